// File: rtl/rom_b_ctrl.sv
// rtl/rom_b_ctrl.sv - mix-layer bias ROM sequencer with credit-based 2-entry output FIFO
// Optional build macro: ROM_B_CTRL_ALL_LAYERS_EN (stream layers 0..2 back-to-back per start).
module rom_b_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int HID_DIM = 24,
    parameter int IDX_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        layer_sel,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              bias_valid,
    input  logic              bias_ready,
    output logic [DATA_W-1:0] bias_data,
    output logic [IDX_W-1:0]  bias_idx,
    output logic [1:0]        bias_layer
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0]  issue_idx;
    logic [1:0]        issue_layer;
    logic [IDX_W-1:0]  land_idx;
    logic [1:0]        land_layer;
    logic              inflight;
    logic [1:0]        fifo_cnt;

    logic [DATA_W-1:0] slot1_data;
    logic [IDX_W-1:0]  slot1_idx;
    logic [1:0]        slot1_layer;

    logic              pop;
    logic              push;
    logic [2:0]        occ;
    logic              issue;
    logic              last_idx;
    logic              last_issue;
    logic              accept;
    logic              bad_start;
    logic [1:0]        start_layer;
    logic [ADDR_W-1:0] base;

    assign bias_valid = (fifo_cnt != 2'd0);
    assign pop        = bias_valid && bias_ready;
    assign push       = inflight;

    // Occupancy the FIFO will have at the next edge, before the landing read
    // of the cycle after; issuing only when this is below 2 keeps the FIFO from overflowing.
    assign occ   = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
    assign issue = (state == S_FETCH) && (occ < 3'd2);

    assign last_idx = (issue_idx == IDX_W'(HID_DIM - 1));

`ifdef ROM_B_CTRL_ALL_LAYERS_EN
    assign last_issue  = last_idx && (issue_layer == 2'd2);
    assign accept      = start;
    assign bad_start   = 1'b0;
    assign start_layer = 2'd0;
`else
    assign last_issue  = last_idx;
    assign accept      = start && (layer_sel != 2'd3);
    assign bad_start   = (state == S_IDLE) && start && (layer_sel == 2'd3);
    assign start_layer = layer_sel;
`endif

    always_comb begin
        base = '0;
        case (start_layer)
            2'd1:    base = ADDR_W'(HID_DIM);
            2'd2:    base = ADDR_W'(2 * HID_DIM);
            default: base = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start && accept) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (issue && last_issue) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!inflight && (fifo_cnt == 2'd1) && pop) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_FETCH: busy = 1'b1;
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // rom_addr always shows the next candidate read; it only advances once that
    // read has actually been credited, so a refused read is simply re-presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr    <= '0;
            issue_idx   <= '0;
            issue_layer <= '0;
            land_idx    <= '0;
            land_layer  <= '0;
            inflight    <= 1'b0;
            err         <= 1'b0;
        end else begin
            err      <= bad_start;
            inflight <= issue;
            if ((state == S_IDLE) && accept) begin
                rom_addr    <= base;
                issue_idx   <= '0;
                issue_layer <= start_layer;
            end else if (issue) begin
                land_idx   <= issue_idx;
                land_layer <= issue_layer;
                if (!last_issue) begin
                    rom_addr <= rom_addr + ADDR_W'(1);
                    if (last_idx) begin
                        issue_idx   <= '0;
                        issue_layer <= issue_layer + 2'd1;
                    end else begin
                        issue_idx <= issue_idx + IDX_W'(1);
                    end
                end
            end
        end
    end

    // Two-entry FIFO: the head registers drive the outputs directly, slot1 is the spill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_cnt    <= 2'd0;
            bias_data   <= '0;
            bias_idx    <= '0;
            bias_layer  <= '0;
            slot1_data  <= '0;
            slot1_idx   <= '0;
            slot1_layer <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) begin
                        bias_data  <= rom_data;
                        bias_idx   <= land_idx;
                        bias_layer <= land_layer;
                    end else begin
                        slot1_data  <= rom_data;
                        slot1_idx   <= land_idx;
                        slot1_layer <= land_layer;
                    end
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    bias_data  <= slot1_data;
                    bias_idx   <= slot1_idx;
                    bias_layer <= slot1_layer;
                    fifo_cnt   <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        bias_data  <= rom_data;
                        bias_idx   <= land_idx;
                        bias_layer <= land_layer;
                    end else begin
                        bias_data   <= slot1_data;
                        bias_idx    <= slot1_idx;
                        bias_layer  <= slot1_layer;
                        slot1_data  <= rom_data;
                        slot1_idx   <= land_idx;
                        slot1_layer <= land_layer;
                    end
                end
                default: begin
                    fifo_cnt <= fifo_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_b_ctrl.sv
// tb/tb_rom_b_ctrl.sv - directed self-checking bench for rom_b_ctrl
module tb_rom_b_ctrl;

    localparam int HID = 24;
`ifdef ROM_B_CTRL_ALL_LAYERS_EN
    localparam bit ALL = 1'b1;
`else
    localparam bit ALL = 1'b0;
`endif
    localparam int NW = ALL ? 3 * HID : HID;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  layer_sel = 2'd0;
    logic        busy, done, err;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic        bias_valid;
    logic        bias_ready = 1'b0;
    logic [15:0] bias_data;
    logic [4:0]  bias_idx;
    logic [1:0]  bias_layer;

    int n_chk  = 0;
    int n_fail = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    rom_b_ctrl #(.DATA_W(16), .ADDR_W(16), .HID_DIM(HID), .IDX_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .layer_sel(layer_sel),
        .busy(busy), .done(done), .err(err),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .bias_valid(bias_valid), .bias_ready(bias_ready),
        .bias_data(bias_data), .bias_idx(bias_idx), .bias_layer(bias_layer)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input int a);
        return 16'hC000 + 16'(a * 7);
    endfunction

    always @(posedge clk) rom_data <= rom_word(int'(rom_addr));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] ls);
        @(negedge clk);
        start = 1'b1;
        layer_sel = ls;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stream(input int first_layer, input int n, input int stop_at,
                          input bit toggle, input bit mid_start);
        int c = 0;
        int got = 0;
        int a;
        int base;
        bit stalled = 1'b0;
        logic [15:0] held = '0;
        base = first_layer * HID;
        while (got < stop_at && c < 4 * n + 20) begin
            bias_ready = toggle ? pat[c % 4] : 1'b1;
            check("busy_run", busy, 1);
            check("done_run", done, 0);
            if (!toggle) begin
                check("rom_addr", rom_addr, base + ((c < n) ? c : n - 1));
                check("valid_lat", bias_valid, (c >= 2) ? 1 : 0);
            end
            if (stalled) begin
                check("stall_valid", bias_valid, 1);
                check("stall_data", bias_data, held);
                stalled = 1'b0;
            end
            if (bias_valid) begin
                if (bias_ready) begin
                    a = base + got;
                    check("bias_data", bias_data, rom_word(a));
                    check("bias_idx", bias_idx, a % HID);
                    check("bias_layer", bias_layer, a / HID);
                    got++;
                end else begin
                    stalled = 1'b1;
                    held = bias_data;
                end
            end
            start = mid_start && (c == 5);
            layer_sel = 2'd0;
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        check("word_count", got, stop_at);
        if (stop_at == n) begin
            check("done_pulse", done, 1);
            check("busy_at_done", busy, 0);
            check("valid_at_done", bias_valid, 0);
            @(negedge clk);
            check("done_single", done, 0);
            check("busy_idle", busy, 0);
            check("valid_idle", bias_valid, 0);
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_valid", bias_valid, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_data", bias_data, 0);
        check("rst_idx", bias_idx, 0);
        check("rst_layer", bias_layer, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_start(2'd1);
        stream(ALL ? 0 : 1, NW, NW, 1'b0, 1'b0);

        if (!ALL) begin
            do_start(2'd3);
            check("err_pulse", err, 1);
            check("err_busy", busy, 0);
            check("err_addr", rom_addr, 47);
            check("err_valid", bias_valid, 0);
            @(negedge clk);
            check("err_single", err, 0);
            check("err_busy2", busy, 0);
            check("err_valid2", bias_valid, 0);
        end else begin
            do_start(2'd3);
            check("err_never", err, 0);
            stream(0, NW, NW, 1'b0, 1'b0);
        end

        do_start(2'd1);
        stream(ALL ? 0 : 1, NW, NW, 1'b1, 1'b0);

        do_start(2'd2);
        stream(ALL ? 0 : 2, NW, NW, 1'b0, 1'b1);

        do_start(2'd1);
        stream(ALL ? 0 : 1, NW, 10, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        check("abort_valid", bias_valid, 0);
        check("abort_addr", rom_addr, 0);
        check("abort_data", bias_data, 0);
        check("abort_idx", bias_idx, 0);
        check("abort_layer", bias_layer, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_abort_done", done, 0);

        do_start(2'd0);
        stream(0, NW, NW, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("final_done", done, 0);
        check("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_b_ctrl.md
Name: rom_b_ctrl

Overview:
- Sequencer for the mix-layer bias ROM.
- On a start request it walks the HID_DIM bias words of one mix layer (0..2) and drives the ROM address.
- It absorbs the ROM's 1-cycle registered read latency and streams biases to the MAC datapath over a valid/ready handshake with full backpressure.
- Sits between the mix-layer top controller and the bias ROM instance.

Parameters:
- DATA_W, 16, bias word width (N_LEN).
- ADDR_W, 16, ROM address width (N_LEN).
- HID_DIM, 24, biases per layer; ROM holds 3*HID_DIM words.
- IDX_W, 5, width of bias_idx; must satisfy 2^IDX_W >= HID_DIM.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- layer_sel  in  2  layer to fetch: 0, 1 or 2; 3 is illegal.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse after the last bias handshake.
- err  out  1  one-cycle pulse when start arrives with layer_sel==3.
- rom_addr  out  ADDR_W  registered address to the ROM.
- rom_data  in  DATA_W  ROM output, valid 1 cycle after rom_addr is presented.
- bias_valid  out  1  head of FIFO valid.
- bias_ready  in  1  consumer accepts; a handshake occurs when bias_valid&&bias_ready.
- bias_data  out  DATA_W  bias word.
- bias_idx  out  IDX_W  index 0..HID_DIM-1 of bias_data within its layer.
- bias_layer  out  2  layer of the current bias_data.

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE
  - busy, done, err, bias_valid = 0
  - rom_addr, bias_data, bias_idx, bias_layer = 0
  - issue counter = 0, in-flight flag = 0, FIFO count = 0
  - Reset mid-operation aborts the fetch; no done is issued.
- States:
  - IDLE: start && layer_sel<3 -> FETCH, base=layer_sel*HID_DIM, issue_cnt=0, busy=1. start && layer_sel==3 -> err pulse next cycle, stay IDLE.
  - FETCH: issues one ROM read per cycle while credit allows. After issuing index HID_DIM-1 -> DRAIN.
  - DRAIN: no issues; waits for the in-flight read to land and the FIFO to empty. The last handshake moves to DONE.
  - DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- Issue rule:
  - A read is issued in cycle t when fifo_cnt + inflight - pop_t < 2, where pop_t = bias_valid&&bias_ready in cycle t.
  - Issue means rom_addr=base+issue_cnt is registered at the edge ending cycle t-1, so it is held during cycle t.
  - rom_data is valid in cycle t+1 and is written into the 2-entry FIFO at the end of cycle t+1. The index and layer are tagged alongside the data.
- Credit guarantees the FIFO never overflows. With bias_ready held high, the throughput is 1 bias/cycle.
- Latency: start sampled at edge E0; rom_addr=base during cycle E0..E1; first bias_valid=1 from edge E2 onward. In other words, the first bias is visible 2 cycles after the start edge.
- Simultaneous push and pop on a full or one-entry FIFO is legal; the count is unchanged.
- bias_valid = (fifo_cnt != 0). bias_data, bias_idx and bias_layer show the FIFO head.
- Data must stay stable while bias_valid && !bias_ready.
- start while busy is ignored and does not raise err.
- rom_addr holds its last value when no read is issued.
- Address arithmetic: base + issue_cnt computed in ADDR_W bits; the maximum is 3*HID_DIM-1, so there is no wrap.

Optional Feature:
- Macro ROM_B_CTRL_ALL_LAYERS_EN.
- Defined:
  - A legal start ignores layer_sel and fetches layers 0, 1, 2 back-to-back as one 3*HID_DIM stream.
  - FETCH rolls base from layer to layer without a bubble, and bias_idx restarts at 0 for each layer.
  - bias_layer follows the layer being streamed.
  - done pulses once, after the final bias of layer 2.
  - err is never raised.
- Undefined: single-layer behaviour as above.

Test Plan:
- HID_DIM=24, layer_sel=1, bias_ready=1 -> rom_addr 24..47 on consecutive cycles; first bias_valid 2 cycles after start. Then 24 consecutive handshakes with bias_idx 0..23, bias_layer=1, bias_data matching ROM words 24..47. done one cycle after idx 23; busy is high throughout.
- Same as above with bias_ready toggling 1,0,0,1 repeatedly -> no word lost or duplicated, data stable during stalls, FIFO count never exceeds 2, done is still a single pulse.
- start with layer_sel=3 -> err=1 for one cycle, busy stays 0, rom_addr unchanged, no bias_valid.
- Second start pulse during layer 2 fetch -> ignored; only addresses 48..71 are emitted, and exactly one done.
- rst asserted while 10 of 24 biases have been delivered -> all outputs 0 immediately. A fresh start on layer 0 afterwards streams idx 0..23 cleanly.
- With ROM_B_CTRL_ALL_LAYERS_EN, start and bias_ready=1 -> 72 handshakes, addresses 0..71 with no bubble at 23/24 or 47/48, bias_idx wrapping 23->0, one done at the end.
